jtframe_rom_nslot: RTL and testbench

JTFRAME_ROM_NSLOT -- requirements
Module: jtframe_rom_nslot

---
 rtl/jtframe_rom_nslot.sv | 185 ++++++++++++++++++
 tb/tb_jtframe_rom_nslot.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_rom_nslot.sv
// N-slot ROM read arbiter: each slot keeps a one-line 32-bit cache and misses
// are serialised onto a single SDRAM read port (fixed or round-robin priority).
module jtframe_rom_nslot #(
  parameter int unsigned        SLOTS       = 4,
  parameter logic [2*SLOTS-1:0] SLOT_DW     = '0,
  parameter logic [22*SLOTS-1:0] SLOT_OFFSET = '0,
  parameter int unsigned        PRIO_MODE   = 0
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic [SLOTS-1:0]      slot_cs,
  input  logic [SLOTS*22-1:0]   slot_addr,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [SLOTS*32-1:0]   slot_dout,
  output logic                  sdram_req,
  output logic [21:0]           sdram_addr,
  input  logic                  sdram_ack,
  input  logic                  data_rdy,
  input  logic [31:0]           data_read,
  input  logic                  downloading,
  input  logic                  loop_rst,
  output logic                  refresh_en
);

  localparam int unsigned IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  function automatic logic [21:0] tag_of(input logic [21:0] addr, input logic [1:0] dw);
    case (dw)
      2'd0:    tag_of = {2'b00, addr[21:2]};
      2'd1:    tag_of = {1'b0, addr[21:1]};
      default: tag_of = addr;
    endcase
  endfunction

  function automatic logic [31:0] dout_sel(input logic [31:0] d, input logic [1:0] lsb,
                                           input logic [1:0] dw);
    case (dw)
      2'd0:    dout_sel = {24'd0, d[{lsb, 3'b000} +: 8]};
      2'd1:    dout_sel = lsb[0] ? {16'd0, d[31:16]} : {16'd0, d[15:0]};
      default: dout_sel = d;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [21:0]      tag_q, tag_d;
  logic [21:0]      addr_q, addr_d;
  logic             req_q, req_d;
  logic [SLOTS-1:0] valid_q, valid_d;
  logic [21:0]      ctag_q [SLOTS];
  logic [21:0]      ctag_d [SLOTS];
  logic [31:0]      data_q [SLOTS];
  logic [31:0]      data_d [SLOTS];

  logic [21:0]      cur_tag [SLOTS];
  logic [SLOTS-1:0] hit, pending;
  logic             hold;
  logic             found;
  logic [IW-1:0]    sel;
  logic [21:0]      sel_tag, sel_off;

  assign hold = downloading | loop_rst;

  always_comb begin
    hit       = '0;
    pending   = '0;
    slot_dout = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      cur_tag[i] = tag_of(slot_addr[22*i +: 22], SLOT_DW[2*i +: 2]);
      hit[i]     = slot_cs[i] & valid_q[i] & (cur_tag[i] == ctag_q[i]) & ~hold;
      pending[i] = slot_cs[i] & ~hit[i] & ~((state_q != IDLE) && (gnt_q == IW'(i)));
      slot_dout[32*i +: 32] = dout_sel(data_q[i], slot_addr[22*i +: 2], SLOT_DW[2*i +: 2]);
    end
  end

  assign slot_ok    = hit;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign refresh_en = (state_q == IDLE) && (pending == '0);

  // Round-robin as two passes: slots above the last grant first, then the wrap.
  always_comb begin
    found   = 1'b0;
    sel     = '0;
    sel_tag = '0;
    sel_off = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!found && pending[i] && (PRIO_MODE != 1 || i > 32'(rr_q))) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!found && pending[i]) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (sel == IW'(i)) begin
        sel_tag = cur_tag[i];
        sel_off = SLOT_OFFSET[22*i +: 22];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    req_d   = req_q;
    valid_d = valid_q;
    ctag_d  = ctag_q;
    data_d  = data_q;
    if (hold) begin
      state_d = IDLE;
      req_d   = 1'b0;
      valid_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            gnt_d   = sel;
            rr_d    = sel;
            tag_d   = sel_tag;
            addr_d  = sel_off + {sel_tag[20:0], 1'b0};
            req_d   = 1'b1;
            state_d = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            req_d   = 1'b0;
            state_d = WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (data_rdy) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
              if (gnt_q == IW'(i)) begin
                valid_d[i] = 1'b1;
                ctag_d[i]  = tag_q;
                data_d[i]  = data_read;
              end
            end
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= IW'(SLOTS - 1);
      tag_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        ctag_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      ctag_q  <= ctag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_jtframe_rom_nslot.sv
// Bench for jtframe_rom_nslot: vector table plus hand sequences; expected SDRAM
// addresses are queued when a miss is driven and popped when the request appears.
module tb_jtframe_rom_nslot;

  localparam logic [7:0]  DW  = {2'd2, 2'd1, 2'd0, 2'd0};
  localparam logic [87:0] OFF = {22'h000000, 22'h3FFFFE, 22'h000000, 22'h001000};

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   cs, ok;
  logic [87:0]  addr;
  logic [127:0] dout;
  logic         req, ack, rdy, dl, lrst, ren;
  logic [21:0]  saddr;
  logic [31:0]  rdata;

  logic [3:0]   r_cs, r_ok;
  logic [87:0]  r_addr;
  logic [127:0] r_dout;
  logic         r_req, r_ack, r_rdy, r_ren;
  logic         r_dl = 1'b0, r_lrst = 1'b0;
  logic [21:0]  r_saddr;
  logic [31:0]  r_rdata;

  jtframe_rom_nslot #(.SLOTS(4), .SLOT_DW(DW), .SLOT_OFFSET(OFF), .PRIO_MODE(0)) u_fix (
    .rst(rst), .clk(clk), .slot_cs(cs), .slot_addr(addr), .slot_ok(ok), .slot_dout(dout),
    .sdram_req(req), .sdram_addr(saddr), .sdram_ack(ack), .data_rdy(rdy), .data_read(rdata),
    .downloading(dl), .loop_rst(lrst), .refresh_en(ren)
  );

  jtframe_rom_nslot #(.SLOTS(4), .SLOT_DW(DW), .SLOT_OFFSET(OFF), .PRIO_MODE(1)) u_rr (
    .rst(rst), .clk(clk), .slot_cs(r_cs), .slot_addr(r_addr), .slot_ok(r_ok), .slot_dout(r_dout),
    .sdram_req(r_req), .sdram_addr(r_saddr), .sdram_ack(r_ack), .data_rdy(r_rdy),
    .data_read(r_rdata), .downloading(r_dl), .loop_rst(r_lrst), .refresh_en(r_ren)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [21:0] sbq[$];
  logic [21:0] rsbq[$];

  typedef struct {
    int          slot;
    logic [21:0] a;
    bit          miss;
    logic [31:0] data;
    logic [21:0] exp_sa;
    logic [31:0] exp_do;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic count_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got no event expected one within 20 cycles", name);
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task settle;
    #1;
  endtask

  task automatic set_slot(input int s, input logic c, input logic [21:0] a);
    cs[s] = c;
    addr[22*s +: 22] = a;
  endtask

  task automatic rset(input int s, input logic [21:0] a);
    r_cs[s] = 1'b1;
    r_addr[22*s +: 22] = a;
  endtask

  task automatic serve_req(input bit bogus, output int waits);
    logic [21:0] prev;
    waits = 0;
    while (!req && waits < 20) begin
      tick;
      waits++;
    end
    if (!req) begin
      count_fail("req_wait");
      return;
    end
    if (sbq.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_empty: got request 0x%06h expected none", saddr);
    end else begin
      chk("sdram_addr", 32'(saddr), 32'(sbq.pop_front()));
    end
    prev = saddr;
    if (bogus) begin
      rdy   = 1'b1;
      rdata = 32'hBAD0BAD0;
    end
    tick;
    rdy = 1'b0;
    settle;
    chk("req_hold", 32'(req), 32'd1);
    chk("addr_hold", 32'(saddr), 32'(prev));
    ack = 1'b1;
    tick;
    ack = 1'b0;
    settle;
    chk("req_drop", 32'(req), 32'd0);
  endtask

  task automatic serve_data(input logic [31:0] d);
    rdy   = 1'b1;
    rdata = d;
    tick;
    rdy   = 1'b0;
    rdata = '0;
    settle;
  endtask

  task automatic rr_serve(input int slot, input logic [31:0] d);
    int waits;
    waits = 0;
    while (!r_req && waits < 20) begin
      tick;
      waits++;
    end
    if (!r_req) begin
      count_fail("rr_req_wait");
      return;
    end
    if (rsbq.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL rr_sb_empty: got request 0x%06h expected none", r_saddr);
    end else begin
      chk("rr_sdram_addr", 32'(r_saddr), 32'(rsbq.pop_front()));
    end
    r_ack = 1'b1;
    tick;
    r_ack   = 1'b0;
    r_rdy   = 1'b1;
    r_rdata = d;
    tick;
    r_rdy = 1'b0;
    settle;
    chk("rr_ok", 32'(r_ok[slot]), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    int w;
    vt[0] = '{0, 22'h000005, 1'b1, 32'h44332211, 22'h001002, 32'h00000022};
    vt[1] = '{0, 22'h000007, 1'b0, 32'h0,        22'h0,      32'h00000044};
    vt[2] = '{0, 22'h000004, 1'b0, 32'h0,        22'h0,      32'h00000011};
    vt[3] = '{2, 22'h000003, 1'b1, 32'hBEEFCAFE, 22'h000000, 32'h0000BEEF};
    vt[4] = '{2, 22'h000002, 1'b0, 32'h0,        22'h0,      32'h0000CAFE};
    vt[5] = '{3, 22'h000010, 1'b1, 32'hDEADBEEF, 22'h000020, 32'hDEADBEEF};
    vt[6] = '{1, 22'h3FFFFF, 1'b1, 32'hA1B2C3D4, 22'h1FFFFE, 32'h000000A1};
    vt[7] = '{1, 22'h3FFFFC, 1'b0, 32'h0,        22'h0,      32'h000000D4};
    vt[8] = '{0, 22'h000005, 1'b0, 32'h0,        22'h0,      32'h00000022};

    rst = 1'b1; cs = '0; addr = '0; ack = 1'b0; rdy = 1'b0; rdata = '0; dl = 1'b0; lrst = 1'b0;
    r_cs = '0; r_addr = '0; r_ack = 1'b0; r_rdy = 1'b0; r_rdata = '0;
    tick;
    tick;
    settle;
    chk("rst_ok", 32'(ok), 32'd0);
    chk("rst_dout", dout[31:0] | dout[63:32] | dout[95:64] | dout[127:96], 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_saddr", 32'(saddr), 32'd0);
    chk("rst_refresh", 32'(ren), 32'd1);
    chk("rst_rr_req", 32'(r_req), 32'd0);
    rst = 1'b0;
    tick;

    for (int v = 0; v < 9; v++) begin
      cs = '0;
      set_slot(vt[v].slot, 1'b1, vt[v].a);
      settle;
      if (vt[v].miss) begin
        chk("miss_ok", 32'(ok[vt[v].slot]), 32'd0);
        chk("miss_refresh", 32'(ren), 32'd0);
        sbq.push_back(vt[v].exp_sa);
        serve_req(v == 0, w);
        if (v == 0) chk("req_latency", 32'(w), 32'd1);
        chk("fill_ok_pre", 32'(ok[vt[v].slot]), 32'd0);
        serve_data(vt[v].data);
      end else begin
        chk("hit_refresh", 32'(ren), 32'd1);
      end
      chk("vec_ok", 32'(ok[vt[v].slot]), 32'd1);
      chk("vec_dout", dout[32*vt[v].slot +: 32], vt[v].exp_do);
      if (!vt[v].miss) begin
        tick;
        chk("hit_no_req", 32'(req), 32'd0);
      end
    end

    // fixed priority: slots 1 and 3 miss together
    cs = '0;
    set_slot(1, 1'b1, 22'h000100);
    set_slot(3, 1'b1, 22'h000200);
    settle;
    sbq.push_back(22'h000080);
    sbq.push_back(22'h000400);
    serve_req(1'b0, w);
    serve_data(32'h0F0E0D0C);
    chk("prio_ok1", 32'(ok[1]), 32'd1);
    chk("prio_ok3_wait", 32'(ok[3]), 32'd0);
    chk("prio_dout1", dout[63:32], 32'h0000000C);
    serve_req(1'b0, w);
    serve_data(32'h13579BDF);
    chk("prio_ok3", 32'(ok[3]), 32'd1);
    chk("prio_dout3", dout[127:96], 32'h13579BDF);
    chk("prio_all_hit_refresh", 32'(ren), 32'd1);

    // address change while the fill is outstanding
    cs = '0;
    set_slot(1, 1'b1, 22'h000010);
    settle;
    sbq.push_back(22'h000008);
    serve_req(1'b0, w);
    set_slot(1, 1'b1, 22'h000020);
    settle;
    chk("chg_refresh_busy", 32'(ren), 32'd0);
    serve_data(32'h11223344);
    chk("chg_ok", 32'(ok[1]), 32'd0);
    chk("chg_refresh_pend", 32'(ren), 32'd0);
    set_slot(1, 1'b1, 22'h000011);
    settle;
    chk("chg_old_tag_ok", 32'(ok[1]), 32'd1);
    chk("chg_old_tag_dout", dout[63:32], 32'h00000033);
    chk("chg_hit_refresh", 32'(ren), 32'd1);
    set_slot(1, 1'b1, 22'h000020);
    settle;
    chk("chg_new_miss", 32'(ok[1]), 32'd0);
    sbq.push_back(22'h000010);
    serve_req(1'b0, w);
    serve_data(32'h55667788);
    chk("chg_new_ok", 32'(ok[1]), 32'd1);
    chk("chg_new_dout", dout[63:32], 32'h00000088);

    // downloading during WAIT_DATA
    cs = '0;
    set_slot(3, 1'b1, 22'h000030);
    settle;
    sbq.push_back(22'h000060);
    serve_req(1'b0, w);
    set_slot(0, 1'b1, 22'h000005);
    settle;
    chk("dl_pre_hit", 32'(ok[0]), 32'd1);
    dl = 1'b1;
    settle;
    chk("dl_ok_zero", 32'(ok), 32'd0);
    tick;
    dl = 1'b0;
    cs = '0;
    settle;
    chk("dl_req", 32'(req), 32'd0);
    chk("dl_idle_refresh", 32'(ren), 32'd1);
    rdy   = 1'b1;
    rdata = 32'h99999999;
    tick;
    rdy = 1'b0;
    set_slot(3, 1'b1, 22'h000030);
    set_slot(0, 1'b1, 22'h000005);
    settle;
    chk("dl_discard_ok3", 32'(ok[3]), 32'd0);
    chk("dl_miss_ok0", 32'(ok[0]), 32'd0);
    sbq.push_back(22'h001002);
    sbq.push_back(22'h000060);
    serve_req(1'b0, w);
    serve_data(32'h44332211);
    chk("dl_refill_dout0", dout[31:0], 32'h00000022);
    serve_req(1'b0, w);
    serve_data(32'h0000ABCD);
    chk("dl_refill_ok3", 32'(ok[3]), 32'd1);
    chk("dl_refill_dout3", dout[127:96], 32'h0000ABCD);

    // round-robin instance
    r_cs = '0;
    rset(0, 22'h000008);
    rset(3, 22'h000040);
    settle;
    rsbq.push_back(22'h001004);
    rsbq.push_back(22'h000080);
    rr_serve(0, 32'h00000001);
    rr_serve(3, 32'h00000002);
    rset(0, 22'h00000C);
    rset(3, 22'h000041);
    settle;
    rsbq.push_back(22'h001006);
    rsbq.push_back(22'h000082);
    rr_serve(0, 32'h00000003);
    rr_serve(3, 32'h00000004);
    r_cs = '0;
    rset(1, 22'h000020);
    settle;
    rsbq.push_back(22'h000010);
    rr_serve(1, 32'h00000005);
    r_cs = '0;
    rset(0, 22'h000008);
    rset(2, 22'h000010);
    settle;
    rsbq.push_back(22'h00000E);
    rsbq.push_back(22'h001004);
    rr_serve(2, 32'h12345A5A);
    rr_serve(0, 32'h00000006);
    chk("rr_dout2", r_dout[95:64], 32'h00005A5A);
    chk("rr_refresh", 32'(r_ren), 32'd1);

    // loop_rst invalidate, then reset in the middle of a transaction
    lrst = 1'b1;
    settle;
    chk("lrst_ok_zero", 32'(ok), 32'd0);
    tick;
    lrst = 1'b0;
    settle;
    chk("lrst_miss", 32'(ok[0]), 32'd0);
    chk("lrst_refresh", 32'(ren), 32'd0);
    sbq.push_back(22'h001002);
    serve_req(1'b0, w);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    cs  = '0;
    settle;
    chk("mrst_req", 32'(req), 32'd0);
    chk("mrst_saddr", 32'(saddr), 32'd0);
    chk("mrst_refresh", 32'(ren), 32'd1);
    rdy   = 1'b1;
    rdata = 32'h77777777;
    tick;
    rdy = 1'b0;
    set_slot(0, 1'b1, 22'h000005);
    settle;
    chk("mrst_ignored", 32'(ok[0]), 32'd0);
    sbq.push_back(22'h001002);
    serve_req(1'b0, w);
    serve_data(32'h44332211);
    chk("mrst_refill_ok", 32'(ok[0]), 32'd1);
    chk("mrst_refill_dout", dout[31:0], 32'h00000022);
    chk("sb_drained", 32'(sbq.size() + rsbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
